// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch sequencer.
//
// Keeps the program counter, issues one instruction-memory request per FETCH
// strobe, captures the returned word into the instruction register and
// advances the PC. It also applies absolute or PC-relative branch loads, and
// stops for good (until reset) once a halt instruction (opcode 15) is fetched.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a 4-bit request timeout.
// After 16 REQ cycles without an acknowledge the unit enters FAULT. FAULT is
// sticky until reset. Without the macro the unit waits for the acknowledge
// indefinitely, and fault is tied low.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_f     in   1  asynchronous active-low reset
//   fetch     in   1  strobe: fetch the next instruction (IDLE only)
//   pc_ld     in   1  strobe: load PC with a branch target (IDLE only)
//   br_rel    in   1  1 = target is pc + br_addr, 0 = target is br_addr
//   br_addr   in  16  absolute target or two's-complement offset
//   im_req    out  1  instruction memory request
//   im_addr   out 16  instruction memory word address (always pc)
//   im_ack    in   1  memory acknowledge, im_data valid in the same cycle
//   im_data   in  32  instruction word from memory
//   ir        out 32  instruction register
//   opcode    out  4  ir[31:28]
//   mm        out  4  ir[27:24]
//   pc        out 16  program counter (word address)
//   ir_valid  out  1  one-cycle pulse after ir has been loaded
//   busy      out  1  high while a request is outstanding
//   halted    out  1  sticky: a halt instruction has been fetched
//   fault     out  1  sticky: memory request timed out
// -----------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        fetch,
    input  logic        pc_ld,
    input  logic        br_rel,
    input  logic [15:0] br_addr,
    output logic        im_req,
    output logic [15:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic [15:0] pc,
    output logic        ir_valid,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [3:0] OPC_HALT = 4'hF;

    state_t state;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign im_addr = pc;
    assign opcode  = ir[31:28];
    assign mm      = ir[27:24];

    // NOTE: all state is written with non-blocking assignments so that every
    // register samples the pre-edge values of its neighbours (e.g. the branch
    // target adds to the old pc, not to a value updated earlier in this block).
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= S_IDLE;
            pc       <= 16'h0000;
            ir       <= 32'h0000_0000;
            im_req   <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt  <= 4'd0;
            fault_q  <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A branch load and a fetch in the same cycle: pc takes the
                    // target now, so the request goes out on the new address.
                    if (pc_ld) begin
                        pc <= br_rel ? (pc + br_addr) : br_addr;
                    end
                    if (fetch) begin
                        state  <= S_REQ;
                        im_req <= 1'b1;
                        busy   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt <= 4'd0;
`endif
                    end
                end

                S_REQ: begin
                    if (im_ack) begin
                        ir       <= im_data;
                        ir_valid <= 1'b1;
                        im_req   <= 1'b0;
                        busy     <= 1'b0;
                        // A halt leaves pc pointing at the halt instruction.
                        if (im_data[31:28] == OPC_HALT) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            pc    <= pc + 16'd1;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    // tmo_cnt already holds 15 on the 16th ack-less cycle.
                    else if (tmo_cnt == 4'hF) begin
                        state   <= S_FAULT;
                        im_req  <= 1'b0;
                        busy    <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
`endif
                end

                // HALT and FAULT are left only through reset.
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
